// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM states, word/byte widths and the big-endian byte-lane helper.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE,
    ERR
  } state_e;

  // Byte k of a word sits at bit 24-8k; 3-k equals ~k for a 2-bit index.
  function automatic logic [4:0] lane_lsb(input logic [1:0] k);
    return {~k, 3'b000};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes into big-endian 32-bit words; word is the
// assembled value including the byte being pushed this cycle.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              flush,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    word       = shift_q | (WORD_W'(in_byte) << lane_lsb(idx_q));
    word_ready = push && ((idx_q == 2'd3) || flush);
    shift_d    = shift_q;
    idx_d      = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (push) begin
      // A completed (or flushed partial) word leaves the register empty.
      if (word_ready) begin
        shift_d = '0;
        idx_d   = '0;
      end else begin
        shift_d = word;
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory as words from address 0
// and holds the CPU in reset until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_reset_q;

  logic              accept, overflow, enter_load, push;
  logic [WORD_W-1:0] word;
  logic              word_ready;

  assign accept     = (state_q == LOAD) && bus.in_valid;
  assign overflow   = accept && (count_q == FULL_COUNT);
  assign enter_load = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign push       = accept && !overflow;

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_load),
    .push       (push),
    .in_byte    (bus.in_data),
    .flush      (bus.in_last),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        // Overflow wins over in_last: the extra byte is never written.
        if (overflow) begin
          state_d = ERR;
        end else if (word_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_W-1:0];
          wr_data_d = word;
          count_d   = count_q + 1'b1;
          if (bus.in_last) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= (state_q != DONE);
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign word_count   = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized programs.
module tb_imem_loader;

  localparam int AW  = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cpu_reset, done, err;
  logic [AW:0]   word_count;

  imem_loader_if #(.ADDR_W(AW)) bus();

  imem_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3, M_ERR = 4;
  int          mst;
  logic [7:0]  cur[$];
  int          nwords;
  logic        e_wr_en;
  logic [AW-1:0] e_wr_addr;
  logic [31:0] e_wr_data;
  logic        e_cpu_reset;

  logic [31:0] cap_mem [DEP];
  int          cap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE;
    nwords = 0;
    cur.delete();
    e_wr_en = 1'b0;
    e_wr_addr = '0;
    e_wr_data = '0;
    e_cpu_reset = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] w;
    e_cpu_reset = (mst != M_DONE);
    e_wr_en = 1'b0;
    case (mst)
      M_IDLE, M_DONE, M_ERR: begin
        if (start) begin
          mst = M_LOAD;
          nwords = 0;
          cur.delete();
        end
      end
      M_LOAD: begin
        if (bus.in_valid) begin
          if (nwords == DEP) begin
            mst = M_ERR;
          end else begin
            cur.push_back(bus.in_data);
            if (cur.size() == 4 || bus.in_last) begin
              w = '0;
              foreach (cur[i]) w[31-8*i -: 8] = cur[i];
              e_wr_en = 1'b1;
              e_wr_addr = AW'(nwords);
              e_wr_data = w;
              nwords++;
              cur.delete();
              if (bus.in_last) mst = M_DRAIN;
            end
          end
        end
      end
      M_DRAIN: mst = M_DONE;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("in_ready",   32'(bus.in_ready), 32'(mst == M_LOAD));
    chk("done",       32'(done),         32'(mst == M_DONE));
    chk("err",        32'(err),          32'(mst == M_ERR));
    chk("cpu_reset",  32'(cpu_reset),    32'(e_cpu_reset));
    chk("word_count", 32'(word_count),   32'(nwords));
    chk("wr_en",      32'(bus.wr_en),    32'(e_wr_en));
    chk("wr_addr",    32'(bus.wr_addr),  32'(e_wr_addr));
    chk("wr_data",    bus.wr_data,       e_wr_data);
  endtask

  // Model advances on each rising edge; outputs are compared on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset(); else model_step();
      @(negedge clk);
      if (!reset) model_reset();
      compare_all();
      if (bus.wr_en === 1'b1) begin
        cap_mem[bus.wr_addr] = bus.wr_data;
        cap_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int g = 0;
    while (g < 8 && $urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      start        = ($urandom_range(7) == 0);
      tick();
      g++;
    end
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_prog(input logic [7:0] p[$], input logic with_last, input int gap_pct);
    foreach (p[i]) begin
      if (mst != M_LOAD) break;
      send_byte(p[i], with_last && (i == p.size() - 1), gap_pct);
    end
  endtask

  initial begin
    logic [7:0]  prog[$];
    logic [6:0]  pat;
    logic [7:0]  gb [4];
    int          base, cyc, idx, len, gap;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_cpu_reset",  32'(cpu_reset),   32'd1);
    chk("rst_in_ready",   32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",      32'(bus.wr_en),   32'd0);
    chk("rst_word_count", 32'(word_count),  32'd0);
    chk("rst_done_err",   32'({done, err}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic two-word load
    pulse_start();
    base = cap_cnt;
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    send_prog(prog, 1'b1, 0);
    chk("basic_last_wr_en",   32'(bus.wr_en),  32'd1);
    chk("basic_last_wr_data", bus.wr_data,     32'hAC080000);
    cyc = 0;
    while (cpu_reset !== 1'b0 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("basic_cpu_reset_latency", 32'(cyc), 32'd2);
    #1;
    chk("basic_done",       32'(done),          32'd1);
    chk("basic_word_count", 32'(word_count),    32'd2);
    chk("basic_writes",     32'(cap_cnt - base), 32'd2);
    chk("basic_mem0",       cap_mem[0],         32'h20080005);
    chk("basic_mem1",       cap_mem[1],         32'hAC080000);

    // Partial final word
    pulse_start();
    base = cap_cnt;
    prog = '{8'h12, 8'h34, 8'h56};
    send_prog(prog, 1'b1, 0);
    repeat (3) tick();
    chk("partial_writes", 32'(cap_cnt - base), 32'd1);
    chk("partial_mem0",   cap_mem[0],          32'h12345600);
    chk("partial_count",  32'(word_count),     32'd1);
    chk("partial_done",   32'(done),           32'd1);

    // Gapped valid pattern 1,0,0,1,1,0,1 carrying AA BB CC DD
    pulse_start();
    base = cap_cnt;
    pat = 7'b1011001;
    gb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat[i];
      bus.in_data  = pat[i] ? gb[idx] : 8'($urandom);
      bus.in_last  = pat[i] ? (idx == 3) : 1'b1;
      tick();
      if (pat[i]) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) tick();
    chk("gaps_writes", 32'(cap_cnt - base), 32'd1);
    chk("gaps_mem0",   cap_mem[0],          32'hAABBCCDD);
    chk("gaps_done",   32'(done),           32'd1);

    // Overflow: 17 bytes into a 4-word memory
    pulse_start();
    base = cap_cnt;
    prog.delete();
    for (int i = 1; i <= 17; i++) prog.push_back(8'(i));
    send_prog(prog, 1'b1, 0);
    chk("ovf_err",       32'(err),           32'd1);
    chk("ovf_in_ready",  32'(bus.in_ready),  32'd0);
    chk("ovf_wr_en",     32'(bus.wr_en),     32'd0);
    repeat (3) tick();
    chk("ovf_writes",    32'(cap_cnt - base), 32'd4);
    chk("ovf_count",     32'(word_count),    32'd4);
    chk("ovf_cpu_reset", 32'(cpu_reset),     32'd1);
    chk("ovf_mem3",      cap_mem[3],         32'h0D0E0F10);
    pulse_start();
    chk("ovf_restart_count", 32'(word_count),   32'd0);
    chk("ovf_restart_ready", 32'(bus.in_ready), 32'd1);
    prog = '{8'h01};
    send_prog(prog, 1'b1, 0);
    repeat (3) tick();

    // Exactly DEPTH words is legal
    pulse_start();
    prog.delete();
    for (int i = 0; i < 4 * DEP; i++) prog.push_back(8'(8'h80 + i));
    send_prog(prog, 1'b1, 0);
    repeat (3) tick();
    chk("full_done",  32'({done, err}),  32'b10);
    chk("full_count", 32'(word_count),   32'd4);
    chk("full_mem3",  cap_mem[3],        32'h8C8D8E8F);

    // Reset mid-load: once with a write pending, once after byte 2 of word 1
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      prog.delete();
      for (int i = 0; i < 4 + 2 * r; i++) prog.push_back(8'(8'h50 + i));
      send_prog(prog, 1'b0, 0);
      if (r == 0) chk("rstmid_wr_pending", 32'(bus.wr_en), 32'd1);
      reset = 1'b0;
      #1;
      chk("rstmid_wr_en",     32'(bus.wr_en),   32'd0);
      chk("rstmid_cpu_reset", 32'(cpu_reset),   32'd1);
      chk("rstmid_idle",      32'({bus.in_ready, done, err}), 32'd0);
      tick();
      reset = 1'b1;
      tick();
    end
    chk("rstmid_mem_kept", cap_mem[0], 32'h50515253);
    pulse_start();
    prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_prog(prog, 1'b1, 0);
    repeat (3) tick();
    chk("rstmid_rewrite", cap_mem[0], 32'hDEADBEEF);

    // Reload from DONE
    pulse_start();
    chk("reload_done_low",    32'(done),      32'd0);
    chk("reload_cpurst_lag",  32'(cpu_reset), 32'd0);
    tick();
    chk("reload_cpurst_high", 32'(cpu_reset), 32'd1);
    prog = '{8'h00, 8'h00, 8'h00, 8'h0C};
    send_prog(prog, 1'b1, 0);
    repeat (3) tick();
    chk("reload_mem0", cap_mem[0],               32'h0000000C);
    chk("reload_done", 32'({done, word_count}),  {28'd0, 1'b1, 3'd1});

    // Randomized programs with gaps, stray starts and idle noise
    for (int n = 0; n < 40; n++) begin
      for (int k = $urandom_range(3); k > 0; k--) begin
        bus.in_valid = 1'($urandom);
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      pulse_start();
      len = $urandom_range(1, 20);
      gap = $urandom_range(0, 60);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      send_prog(prog, 1'b1, gap);
      repeat (3) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
